jtag_tx_arbiter: RTL and testbench

//  Shares the single byte-wide transmit channel of the USB-JTAG host link between NREQ on-chip

---
 rtl/jtag_link_pkg.sv | 12 +
 rtl/jtag_tx_arbiter_rr_pick.sv | 27 ++
 rtl/jtag_tx_arbiter.sv | 111 +++++++++++
 tb/tb_jtag_tx_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_link_pkg.sv
// Shared types and widths for the USB-JTAG transmit path.
package jtag_link_pkg;
    localparam int BYTE_W   = 8;
    localparam int MAX_NREQ = 8;
    localparam int GRANT_W  = $clog2(MAX_NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } arbState_t;
endpackage

// File: rtl/jtag_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
    import jtag_link_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]    req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               valid,
    output logic [GRANT_W-1:0] idx
);
    logic [NREQ-1:0] rotated;

    always_comb begin
        valid   = 1'b0;
        idx     = '0;
        rotated = '0;
        // Scan farthest-first so the nearest requester at or after ptr is the last to win.
        for (int i = NREQ - 1; i >= 0; i--) begin
            rotated = req >> ((int'(ptr) + i) % NREQ);
            if (rotated[0]) begin
                valid = 1'b1;
                idx   = GRANT_W'((int'(ptr) + i) % NREQ);
            end
        end
    end
endmodule

// File: rtl/jtag_tx_arbiter.sv
// Round-robin arbiter sharing the byte-wide USB-JTAG transmit channel between NREQ requesters.
//   state  | meaning
//   S_IDLE | waiting for an unheld request; picks the next grantee
//   S_SEND | byte presented with oTxD_Start high until Done or timeout
//   S_GAP  | Start low for GAP cycles so the link bit counter can reset
module jtag_tx_arbiter
    import jtag_link_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096,
    parameter int GAP     = 2
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [NREQ-1:0]        iREQ,
    input  logic [BYTE_W*NREQ-1:0] iDATA,
    input  logic                   iHold,
    output logic [NREQ-1:0]        oACK,
    output logic [NREQ-1:0]        oERR,
    output logic [BYTE_W-1:0]      oTxD_DATA,
    output logic                   oTxD_Start,
    input  logic                   iTxD_Done,
    output logic                   oBusy,
    output logic [GRANT_W-1:0]     oGrant
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

    arbState_t          state, nextState;
    logic [GRANT_W-1:0] ptr, pickIdx, nextPtr;
    logic               pickValid, grantEv, doneEv, timeoutEv;
    logic [TMR_W-1:0]   timer;
    logic [GAP_W-1:0]   gapCnt;
    logic [BYTE_W-1:0]  pickByte;
    logic [NREQ-1:0]    grantMask;

    rr_pick #(.NREQ(NREQ)) uPick (
        .req   (iREQ),
        .ptr   (ptr),
        .valid (pickValid),
        .idx   (pickIdx)
    );

    assign pickByte  = BYTE_W'(iDATA >> (BYTE_W * int'(pickIdx)));
    assign grantMask = NREQ'(1) << oGrant;
    assign nextPtr   = (oGrant == GRANT_W'(NREQ - 1)) ? '0 : oGrant + GRANT_W'(1);

    always_ff @(posedge iCLK) begin
        if (iRST) state <= S_IDLE;
        else      state <= nextState;
    end

    // Done is checked before the timer so a coincident Done wins over the abort.
    always_comb begin
        nextState = state;
        grantEv   = 1'b0;
        doneEv    = 1'b0;
        timeoutEv = 1'b0;
        case (state)
            S_IDLE: if (!iHold && pickValid) begin
                grantEv   = 1'b1;
                nextState = S_SEND;
            end
            S_SEND: if (iTxD_Done) begin
                doneEv    = 1'b1;
                nextState = S_GAP;
            end else if (timer == TMR_LAST) begin
                timeoutEv = 1'b1;
                nextState = S_GAP;
            end
            S_GAP:   if (gapCnt == '0) nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    always_comb begin
        oTxD_Start = (state == S_SEND);
        oBusy      = (state != S_IDLE);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ptr       <= '0;
            oGrant    <= '0;
            oTxD_DATA <= '0;
            timer     <= '0;
            gapCnt    <= '0;
            oACK      <= '0;
            oERR      <= '0;
        end else begin
            oACK <= doneEv    ? grantMask : '0;
            oERR <= timeoutEv ? grantMask : '0;
            if (grantEv) begin
                oGrant    <= pickIdx;
                oTxD_DATA <= pickByte;
                timer     <= '0;
            end else if (state == S_SEND && timer != TMR_MAX) begin
                timer <= timer + TMR_W'(1);
            end
            if (doneEv || timeoutEv) begin
                ptr    <= nextPtr;
                gapCnt <= GAP_LOAD;
            end else if (state == S_GAP && gapCnt != '0) begin
                gapCnt <= gapCnt - GAP_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_jtag_tx_arbiter.sv
// Directed plus randomized bench for jtag_tx_arbiter with a round-robin reference model.
module tb_jtag_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int GAP     = 2;

    logic       clk = 1'b0;
    logic       rst, hold, done;
    logic [3:0] reqM, ack, err;
    logic [31:0] dataBus;
    logic [7:0] txData;
    logic       start, busy;
    logic [2:0] grant;

    logic       holdL, doneL, startL, busyL;
    logic [3:0] reqL, ackL, errL;
    logic [31:0] dataL;
    logic [7:0] txL;
    logic [2:0] grantL;

    int         nAsserts = 0;
    int         nFails   = 0;
    int         mPtr;
    logic [7:0] bytes [NREQ];

    always #5 clk = ~clk;

    jtag_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .iCLK(clk), .iRST(rst), .iREQ(reqM), .iDATA(dataBus), .iHold(hold),
        .oACK(ack), .oERR(err), .oTxD_DATA(txData), .oTxD_Start(start),
        .iTxD_Done(done), .oBusy(busy), .oGrant(grant)
    );

    jtag_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(4096), .GAP(GAP)) dutLong (
        .iCLK(clk), .iRST(rst), .iREQ(reqL), .iDATA(dataL), .iHold(holdL),
        .oACK(ackL), .oERR(errL), .oTxD_DATA(txL), .oTxD_Start(startL),
        .iTxD_Done(doneL), .oBusy(busyL), .oGrant(grantL)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NREQ; k++) dataBus[8*k +: 8] = bytes[k];
    endtask

    // Reference rule: first pending requester at or after the pointer, wrapping.
    function automatic int modelPick(input logic [3:0] mask, input int p);
        for (int i = 0; i < NREQ; i++)
            if (mask[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    // One granted byte: wait for Start, hold Done until doneAt (0 = never), check outcome.
    // midAct 1 raises iHold on SEND cycle 2; midAct 2 drops the grantee's request then.
    task automatic xfer(input int doneAt, input int expWait, input int midAct, input bit keepReq);
        int g, n, len;
        bit ackExp;
        g = modelPick(reqM, mPtr);
        n = 0;
        do begin
            tick();
            n++;
            if (!start) chk("idleNoPulse", {24'h0, ack, err}, 32'h0);
        end while (!start && n < 64);
        chk("startSeen", {31'h0, start}, 32'h1);
        if (expWait >= 0) chk("startLatency", n, expWait);
        chk("grant", {29'h0, grant}, g);
        len = 0;
        while (start === 1'b1 && len < 64) begin
            len++;
            chk("dataHeld", {24'h0, txData}, {24'h0, bytes[g]});
            if (len == 2 && midAct == 1) hold = 1'b1;
            if (len == 2 && midAct == 2) reqM[g] = 1'b0;
            if (len == doneAt) done = 1'b1;
            tick();
            done = 1'b0;
        end
        ackExp = (doneAt >= 1 && doneAt <= TIMEOUT);
        chk("startLen", len, ackExp ? doneAt : TIMEOUT);
        chk("ack", {28'h0, ack}, ackExp ? (32'h1 << g) : 32'h0);
        chk("err", {28'h0, err}, ackExp ? 32'h0 : (32'h1 << g));
        mPtr = (g + 1) % NREQ;
        if (!keepReq) reqM[g] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, len;
        logic [3:0] nb;
        rst = 1'b1; hold = 1'b0; done = 1'b0; reqM = '0; dataBus = '0;
        holdL = 1'b0; doneL = 1'b0; reqL = '0; dataL = '0;
        for (int k = 0; k < NREQ; k++) bytes[k] = '0;
        mPtr = 0;
        tick(); tick();
        chk("rstStart", {31'h0, start}, 32'h0);
        chk("rstAckErr", {24'h0, ack, err}, 32'h0);
        chk("rstGrant", {29'h0, grant}, 32'h0);
        chk("rstBusy", {31'h0, busy}, 32'h0);
        chk("rstData", {24'h0, txData}, 32'h0);
        rst = 1'b0;

        // Single requester on the long-timeout instance, Done after 20 Start cycles.
        reqL = 4'b0001; dataL = 32'h0000_00A5;
        tick();
        chk("t1Start", {31'h0, startL}, 32'h1);
        chk("t1Grant", {29'h0, grantL}, 32'h0);
        len = 0;
        for (int c = 1; c <= 20; c++) begin
            if (startL === 1'b1 && txL === 8'hA5) len++;
            if (c == 20) doneL = 1'b1;
            tick();
            doneL = 1'b0;
        end
        chk("t1StartLen", len, 20);
        chk("t1StartLow", {31'h0, startL}, 32'h0);
        chk("t1Ack", {28'h0, ackL}, 32'h1);
        chk("t1Err", {28'h0, errL}, 32'h0);
        reqL = 4'b0000;
        chk("t1GapBusy0", {31'h0, busyL}, 32'h1);
        tick();
        chk("t1AckPulse", {28'h0, ackL}, 32'h0);
        chk("t1GapBusy1", {31'h0, busyL}, 32'h1);
        tick();
        chk("t1Idle", {31'h0, busyL}, 32'h0);

        // Fairness with all four held.
        reqM = 4'b1111;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        drive();
        xfer(5, 1, 0, 1'b1);
        for (int i = 0; i < 4; i++) xfer(5, GAP + 1, 0, 1'b1);

        // Timeout, then the next grant goes to the following requester.
        reqM = 4'b0001; bytes[0] = 8'hE7; drive();
        xfer(0, -1, 0, 1'b0);
        reqM = 4'b0011; bytes[0] = 8'h01; bytes[1] = 8'h02; drive();
        xfer(3, -1, 0, 1'b0);

        // Done on the timeout cycle with iHold raised mid-SEND, then hold blocks grants.
        reqM = 4'b1000; bytes[3] = 8'hC3; drive();
        xfer(TIMEOUT, -1, 1, 1'b0);
        reqM = 4'b0100; bytes[2] = 8'h96; drive();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("holdNoStart", {31'h0, start}, 32'h0);
        end
        hold = 1'b0;
        xfer(4, 1, 0, 1'b0);

        // Reset on the third SEND cycle.
        reqM = 4'b0001; bytes[0] = 8'h5A; drive();
        chk("t5Model", modelPick(reqM, mPtr), 0);
        n = 0;
        do begin tick(); n++; end while (!start && n < 16);
        chk("t5Start", {31'h0, start}, 32'h1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5Start0", {31'h0, start}, 32'h0);
        chk("t5AckErr", {24'h0, ack, err}, 32'h0);
        chk("t5Grant", {29'h0, grant}, 32'h0);
        chk("t5Busy", {31'h0, busy}, 32'h0);
        mPtr = 0;
        reqM = 4'b0010; bytes[1] = 8'h3C; drive();
        xfer(6, 1, 0, 1'b0);

        // Stray Done in IDLE, then requester 1 drops iREQ mid-SEND.
        n = 0;
        do begin tick(); n++; end while (busy && n < 16);
        chk("t6Idle", {31'h0, busy}, 32'h0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t6StrayAckErr", {24'h0, ack, err}, 32'h0);
        chk("t6StrayStart", {31'h0, start}, 32'h0);
        reqM = 4'b0010; bytes[1] = 8'h77; drive();
        xfer(8, 1, 2, 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 24; it++) begin
            nb = 4'($urandom);
            if ((reqM | nb) == 4'b0000) nb = 4'b0001 << $urandom_range(0, 3);
            for (int k = 0; k < NREQ; k++)
                if (nb[k] && !reqM[k]) bytes[k] = 8'($urandom);
            reqM = reqM | nb;
            drive();
            xfer(int'($urandom_range(1, 20)), -1, int'($urandom_range(0, 1)) * 2, 1'b0);
        end

        reqM = '0;
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
